// File: rtl/dmem_line_reader.sv
// CPU-side load/store front end for a 128-bit line-output data memory.
// One 16-byte line buffer serves word loads; stores are written through one word at a time.
module dmem_line_reader #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 CLk,
  input  logic                 reset,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_write,
  input  logic [127:0]         mem_rdata,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  state_t state, state_nxt;

  logic              valid;
  logic [27:0]       tag;
  logic [127:0]      line;
  logic [WAIT_W-1:0] wait_cnt;
  logic              hit;
  logic [1:0]        word_sel;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];
  assign hit       = valid && (tag == cpu_addr[31:4]);
  assign word_sel  = cpu_addr[3:2];
  assign cpu_rdata = line[{word_sel, 5'b00000} +: 32];

  always_ff @(posedge CLk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stores win over loads; a load only stalls when it misses the buffered line.
  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_write) begin
          cpu_stall = 1'b1;
          state_nxt = WRITE;
        end else if (cpu_read && !hit) begin
          cpu_stall = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        cpu_stall = 1'b1;
        if (wait_cnt == '0) begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLk) begin
    if (reset) begin
      valid      <= 1'b0;
      tag        <= '0;
      line       <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_write  <= 1'b0;
      miss_count <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_write) begin
            mem_addr  <= {cpu_addr[31:2], 2'b00};
            mem_wdata <= cpu_wdata;
            mem_write <= 1'b1;
            if (hit) begin
              line[{word_sel, 5'b00000} +: 32] <= cpu_wdata;
            end
          end else if (cpu_read && !hit) begin
            // Tag is claimed now but stays invalid until the line actually lands.
            mem_addr <= {cpu_addr[31:4], 4'h0};
            tag      <= cpu_addr[31:4];
            wait_cnt <= WAIT_INIT;
            valid    <= 1'b0;
            if (miss_count != '1) begin
              miss_count <= miss_count + 1'b1;
            end
          end
        end
        FILL: begin
          if (wait_cnt == '0) begin
            line  <= mem_rdata;
            valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        WRITE: begin
          mem_write <= 1'b0;
        end
        default: begin
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_reader.sv
// Directed bench for dmem_line_reader: transaction-level reference model plus literal spot checks.
module tb_dmem_line_reader;

  localparam int MEM_LATENCY = 4;
  localparam int CNT_WIDTH   = 4;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic                 cpu_read;
  logic                 cpu_write;
  logic [31:0]          cpu_rdata;
  logic                 cpu_stall;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic                 mem_write;
  logic [127:0]         mem_rdata;
  logic [CNT_WIDTH-1:0] miss_count;

  always #5 clk = ~clk;

  dmem_line_reader #(.MEM_LATENCY(MEM_LATENCY), .CNT_WIDTH(CNT_WIDTH)) dut (
    .CLk(clk),
    .reset(reset),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read),
    .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .miss_count(miss_count)
  );

  // Memory seen by the DUT, and the bench's own reference copy of it.
  logic [7:0] dmem    [0:4095];
  logic [7:0] ref_mem [0:4095];

  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < 16; k++) begin
      mem_rdata[8*k +: 8] = dmem[{mem_addr[11:4], 4'(k)}];
    end
  end

  always @(posedge clk) begin
    if (mem_write) begin
      for (int b = 0; b < 4; b++) begin
        dmem[{mem_addr[11:2], 2'b00} + b] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Reference model state: buffer presence, miss count and last memory request.
  bit          m_valid;
  logic [27:0] m_tag;
  int          m_miss;
  logic [31:0] m_maddr;
  logic [31:0] m_wdata;

  bit          chk_en;
  logic        exp_stall;
  logic        exp_mwrite;
  bit          chk_rdata;
  logic [31:0] exp_rdata;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_tag   = '0;
    m_miss  = 0;
    m_maddr = '0;
    m_wdata = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_stall", 128'(cpu_stall), 128'(exp_stall));
      check("mem_write", 128'(mem_write), 128'(exp_mwrite));
      check("mem_addr", 128'(mem_addr), 128'(m_maddr));
      check("mem_wdata", 128'(mem_wdata), 128'(m_wdata));
      check("miss_count", 128'(miss_count), 128'(m_miss));
      if (chk_rdata) begin
        check("cpu_rdata", 128'(cpu_rdata), 128'(exp_rdata));
      end
    end
  end

  task automatic idle(input int n);
    cpu_read   = 1'b0;
    cpu_write  = 1'b0;
    exp_stall  = 1'b0;
    exp_mwrite = 1'b0;
    chk_rdata  = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A load lasts one cycle on a hit, MEM_LATENCY+2 cycles on a miss.
  task automatic do_read(input logic [31:0] addr, output int stalls,
                         output logic [31:0] data, output logic [31:0] fill_addr);
    bit hit;
    int pred;
    hit       = m_valid && (m_tag == addr[31:4]);
    pred      = hit ? 0 : MEM_LATENCY + 1;
    stalls    = 0;
    data      = '0;
    fill_addr = '0;
    cpu_addr  = addr;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    exp_mwrite = 1'b0;
    for (int c = 0; c <= pred; c++) begin
      if (!hit && c == 1) begin
        if (m_miss < CNT_MAX) m_miss++;
        m_maddr = {addr[31:4], 4'h0};
      end
      exp_stall = (c < pred);
      chk_rdata = (c == pred);
      exp_rdata = ref_word(addr);
      @(negedge clk);
      if (cpu_stall === 1'b1) stalls++;
      if (c == 2) fill_addr = mem_addr;
      if (c == pred) data = cpu_rdata;
      @(posedge clk);
      #1;
    end
    m_valid   = 1;
    m_tag     = addr[31:4];
    cpu_read  = 1'b0;
    chk_rdata = 0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic rd,
                          output int pulses, output logic [31:0] waddr, output logic [31:0] wdat);
    pulses    = 0;
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_write = 1'b1;
    cpu_read  = rd;
    chk_rdata = 0;
    exp_stall = 1'b1;
    exp_mwrite = 1'b0;
    @(negedge clk);
    if (mem_write === 1'b1) pulses++;
    @(posedge clk);
    #1;
    m_maddr = {addr[31:2], 2'b00};
    m_wdata = data;
    for (int b = 0; b < 4; b++) ref_mem[{addr[11:2], 2'b00} + b] = data[8*b +: 8];
    exp_stall  = 1'b0;
    exp_mwrite = 1'b1;
    @(negedge clk);
    if (mem_write === 1'b1) pulses++;
    waddr = mem_addr;
    wdat  = mem_wdata;
    @(posedge clk);
    #1;
    cpu_write  = 1'b0;
    cpu_read   = 1'b0;
    exp_mwrite = 1'b0;
    exp_stall  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    int          pc;
    logic [31:0] d;
    logic [31:0] fa;
    logic [31:0] wa;
    logic [31:0] wd;

    for (int i = 0; i < 4096; i++) begin
      dmem[i]    = 8'(i);
      ref_mem[i] = 8'(i);
    end
    chk_en    = 0;
    chk_rdata = 0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    exp_stall  = 1'b0;
    exp_mwrite = 1'b0;
    exp_rdata  = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk_en = 1;
    check("reset_miss_count", 128'(miss_count), 128'(0));
    check("reset_mem_addr", 128'(mem_addr), 128'(0));
    idle(1);

    // First load misses, then a second load in the same line hits.
    do_read(32'h14, st, d, fa);
    check("rd14_stall_cycles", 128'(st), 128'(5));
    check("rd14_fill_addr", 128'(fa), 128'(32'h10));
    check("rd14_data", 128'(d), 128'(32'h17161514));
    check("rd14_miss_count", 128'(miss_count), 128'(1));
    do_read(32'h1C, st, d, fa);
    check("rd1c_stall_cycles", 128'(st), 128'(0));
    check("rd1c_data", 128'(d), 128'(32'h1F1E1D1C));

    // Store hitting the buffered line, then loads.
    do_write(32'h18, 32'hDEADBEEF, 1'b0, pc, wa, wd);
    check("wr18_pulses", 128'(pc), 128'(1));
    check("wr18_addr", 128'(wa), 128'(32'h18));
    check("wr18_data", 128'(wd), 128'(32'hDEADBEEF));
    idle(1);
    do_read(32'h18, st, d, fa);
    check("rd18_after_store", 128'(d), 128'(32'hDEADBEEF));
    check("rd18_stall_cycles", 128'(st), 128'(0));
    do_read(32'h40, st, d, fa);
    check("rd40_data", 128'(d), 128'(32'h43424140));
    check("rd40_stall_cycles", 128'(st), 128'(5));

    // No-allocate store outside the buffered line.
    do_read(32'h14, st, d, fa);
    do_write(32'h200, 32'h12345678, 1'b0, pc, wa, wd);
    do_read(32'h14, st, d, fa);
    check("rd14_after_far_store_stall", 128'(st), 128'(0));
    check("rd14_after_far_store_data", 128'(d), 128'(32'h17161514));

    // Reset in the second FILL cycle aborts the refill.
    cpu_addr  = 32'h54;
    cpu_read  = 1'b1;
    exp_stall = 1'b1;
    exp_mwrite = 1'b0;
    @(posedge clk);
    #1;
    if (m_miss < CNT_MAX) m_miss++;
    m_maddr = 32'h50;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    cpu_read = 1'b0;
    model_reset();
    idle(1);
    check("abort_miss_count", 128'(miss_count), 128'(0));
    check("abort_mem_write", 128'(mem_write), 128'(0));
    do_read(32'h14, st, d, fa);
    check("abort_reread_stall_cycles", 128'(st), 128'(5));
    check("abort_reread_data", 128'(d), 128'(32'h17161514));

    // Simultaneous read and write is a store only.
    do_write(32'h20, 32'hCAFEF00D, 1'b1, pc, wa, wd);
    check("rw20_pulses", 128'(pc), 128'(1));
    check("rw20_miss_count", 128'(miss_count), 128'(1));
    idle(2);

    // Drive the miss counter to saturation and past it.
    for (int i = 0; i < 40 && m_miss < CNT_MAX; i++) begin
      do_read(32'h100 + 32'(i) * 32'h10, st, d, fa);
    end
    check("sat_reached", 128'(miss_count), 128'(CNT_MAX));
    do_read(32'h400, st, d, fa);
    check("sat_held", 128'(miss_count), 128'(CNT_MAX));
    check("rd400_data", 128'(d), 128'(32'h03020100));
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_line_reader.md
Name: dmem_line_reader

Overview:
- CPU-side initiator for the 128-bit line-output data memory.
- Holds one 16-byte line buffer and serves 32-bit CPU loads from it.
- On a buffer miss, drives a line-aligned address to the memory, waits the memory's fixed read interval, then captures the line.
- Stores are write-through, one 32-bit word per request; a store that hits the buffered line also updates the buffer.

Parameters:
- MEM_LATENCY, 4: cycles the line address is held before mem_rdata is captured; must be >= the memory's line-refresh period.
- CNT_WIDTH, 16: width of the saturating miss counter.

Ports:
- CLk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  32  byte address; bits [1:0] ignored (word-aligned).
- cpu_wdata  in  32  store data.
- cpu_read  in  1  load request, level, held until cpu_stall=0.
- cpu_write  in  1  store request, level, held until cpu_stall=0.
- cpu_rdata  out  32  load data, valid when cpu_read=1 and cpu_stall=0.
- cpu_stall  out  1  CPU must hold its request while this is 1.
- mem_addr  out  32  registered memory address.
- mem_wdata  out  32  registered memory write data.
- mem_write  out  1  registered memory write enable.
- mem_rdata  in  128  memory line; byte k of the line is [8k+7:8k].
- miss_count  out  CNT_WIDTH  number of load misses, saturating.

Behaviour:

Reset (synchronous, active-high; takes effect at the next posedge):
- state=IDLE, valid=0, tag=0, line=0.
- mem_addr=0, mem_wdata=0, mem_write=0, miss_count=0, wait counter=0.
- Reset asserted during FILL or WRITE aborts the operation; valid stays 0 and no partial line is kept.

Line buffer:
- valid (1), tag (28, = addr[31:4]), line (128).
- hit = valid && (tag == cpu_addr[31:4]).

cpu_rdata:
- Combinational: line[32*w+31 : 32*w] with w = cpu_addr[3:2], little-endian.
- Value is don't-care when not a hit.

State machine (IDLE, FILL, WRITE):
- IDLE, cpu_write=1 (takes priority over cpu_read):
  - cpu_stall=1 combinationally.
  - Next posedge: mem_addr={cpu_addr[31:2],2'b00}, mem_wdata=cpu_wdata, mem_write=1.
  - If hit, the buffer word w is replaced with cpu_wdata.
  - Go to WRITE.
- WRITE:
  - mem_write=1 for exactly this one cycle; cpu_stall=0.
  - Next posedge: mem_write=0, go to IDLE.
  - Store latency is 2 cycles. Address and data are stable across the cycle's negedge.
- IDLE, cpu_read=1 and hit: cpu_stall=0; single-cycle load; no state change.
- IDLE, cpu_read=1 and miss:
  - cpu_stall=1.
  - Next posedge: mem_addr={cpu_addr[31:4],4'h0}, latch tag=cpu_addr[31:4], counter=MEM_LATENCY-1, valid=0, miss_count+1 (holds at all-ones), go to FILL.
- FILL:
  - cpu_stall=1; CPU inputs are ignored; mem_addr is held.
  - Counter decrements each cycle.
  - At the posedge where counter==0: line=mem_rdata, valid=1, go to IDLE.
  - The load then hits. Total stall is MEM_LATENCY+1 cycles, and the load completes in cycle MEM_LATENCY+2.
- IDLE, no request: cpu_stall=0, mem_write=0, mem_addr holds its last value.

Boundary conditions:
- cpu_read and cpu_write both asserted: treated as a store only.
- Store to an address outside the buffered line: the buffer is unchanged (no-allocate).
- A new request is accepted in the cycle immediately after WRITE or FILL exits (back-to-back operation).
- miss_count does not wrap.

Test Plan:
- Memory byte i initialised to i[7:0]. After reset, cpu_read with cpu_addr=0x14 -> cpu_stall=1 for 5 cycles, mem_addr=0x10 during FILL, then cpu_rdata=0x17161514 with cpu_stall=0, miss_count=1.
- Follow-up cpu_read at 0x1C -> no stall, cpu_rdata=0x1F1E1D1C, miss_count stays 1.
- cpu_write addr=0x18 data=0xDEADBEEF -> exactly one cycle with mem_write=1, mem_addr=0x18, mem_wdata=0xDEADBEEF. A following read at 0x18 hits with 0xDEADBEEF. A read at 0x40 misses and refills 0x43424140.
- cpu_write to 0x200 while the line at 0x10 is valid -> buffer unchanged; a read at 0x14 still hits 0x17161514.
- reset asserted in the 2nd FILL cycle -> next cycle state IDLE, valid=0, mem_write=0, miss_count=0; re-issued read at 0x14 takes the full 5-cycle stall.
- cpu_read and cpu_write asserted together at 0x20 -> store performed (mem_write pulse), no fill started, miss_count unchanged. With the miss counter preloaded to 0xFFFF via repeated misses, a further miss keeps it at 0xFFFF.
